// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - two-flop synchroniser, ms-tick debouncer and press/release pulser per button.
// Optional auto-repeat of btn_press while held: define BTN_CONDITIONER_AUTOREPEAT_EN.
module btn_conditioner #(
  parameter int WIDTH       = 4,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      ticks_per_milli,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_stable,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic             ms_tick
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_MS);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [15:0]      presc_q, presc_d;
  logic [15:0]      limit_m1;
  logic             wrap;
  logic             ms_tick_q, ms_tick_d;
  logic [7:0]       cnt_q [WIDTH];
  logic [7:0]       cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [WIDTH-1:0] repeat_d;

  // A limit change below the current count wraps immediately rather than running to 0xFFFF.
  always_comb begin
    limit_m1  = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
    wrap      = (presc_q >= limit_m1);
    presc_d   = wrap ? 16'd0 : presc_q + 16'd1;
    ms_tick_d = wrap;
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
  end

  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (ms_tick_q) begin
        if (cnt_q[i] + 8'd1 == DB_LIMIT) begin
          stable_d[i]  = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
          cnt_d[i]     = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
  localparam logic [9:0] REPEAT_FIRST  = 10'd500;
  localparam logic [9:0] REPEAT_RELOAD = 10'd400;

  logic [9:0] hold_q [WIDTH];
  logic [9:0] hold_d [WIDTH];

  // Reloading to 400 after each repeat yields the 100 ms cadence without a second counter.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hold_d[i] = hold_q[i];
      if (!stable_q[i]) begin
        hold_d[i] = 10'd0;
      end else if (ms_tick_q) begin
        if ((hold_q[i] + 10'd1 == REPEAT_FIRST) && stable_d[i]) begin
          hold_d[i]   = REPEAT_RELOAD;
          repeat_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= 10'd0;
    end else begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign repeat_d = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= 16'd0;
      ms_tick_q <= 1'b0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= 8'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      presc_q   <= presc_d;
      ms_tick_q <= ms_tick_d;
      stable_q  <= stable_d;
      press_q   <= press_d | repeat_d;
      release_q <= release_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_stable  = stable_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign ms_tick     = ms_tick_q;

endmodule
